// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel compositor: pose encoding,
// sprite-select codes and the fixed 12-bit RGB palettes.
package sprite_pkg;

  typedef enum logic [2:0] {
    POSE_IDLE   = 3'd0,
    POSE_SWING1 = 3'd1,
    POSE_SWING2 = 3'd2,
    POSE_SWING3 = 3'd3,
    POSE_SWING4 = 3'd4
  } pose_t;

  localparam logic [2:0] SEL_WALK_A = 3'd0;
  localparam logic [2:0] SEL_WALK_B = 3'd1;
  localparam logic [2:0] SEL_SWING1 = 3'd2;
  localparam logic [2:0] SEL_SWING2 = 3'd3;
  localparam logic [2:0] SEL_SWING3 = 3'd4;
  localparam logic [2:0] SEL_SWING4 = 3'd5;

  localparam logic [2:0] TRANSPARENT_IDX = 3'd0;

  localparam logic [11:0] SPR_PAL [0:7] = '{
    12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF
  };

  localparam logic [11:0] BG_PAL [0:15] = '{
    12'h000, 12'h124, 12'h248, 12'h36C, 12'h480, 12'h5A4, 12'h6C8, 12'h7E1,
    12'h802, 12'h913, 12'hA24, 12'hB35, 12'hC46, 12'hD57, 12'hE68, 12'hF79
  };

  function automatic logic [2:0] pose_sel(input pose_t pose, input logic walk);
    case (pose)
      POSE_SWING1: return SEL_SWING1;
      POSE_SWING2: return SEL_SWING2;
      POSE_SWING3: return SEL_SWING3;
      POSE_SWING4: return SEL_SWING4;
      default:     return walk ? SEL_WALK_B : SEL_WALK_A;
    endcase
  endfunction

endpackage

// File: rtl/sprite_pixel_compositor_pose_fsm.sv
// Player pose sequencer: swing FSM, pending-attack flag and frame counter.
// Walk-frame toggling is built only when SPRITE_WALK_ANIM_EN is defined.
module pose_fsm
  import sprite_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       moving,
  input  logic       attack,
  output logic [2:0] spr_sel,
  output logic       busy
);

  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  pose_t      r_state,     w_state_nxt;
  logic       r_pending,   w_pending_nxt;
  logic [7:0] r_frame_cnt, w_frame_cnt_nxt;
  logic       r_walk,      w_walk_nxt;
  logic       w_cnt_last;

  assign w_cnt_last = (r_frame_cnt == ANIM_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= POSE_IDLE;
      r_pending   <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_walk      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_walk      <= w_walk_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_frame_cnt_nxt = r_frame_cnt;
    w_walk_nxt      = r_walk;
    case (r_state)
      POSE_IDLE: begin
        if (frame_start && (r_pending || attack)) begin
          w_state_nxt     = POSE_SWING1;
          w_frame_cnt_nxt = 8'd0;
          w_pending_nxt   = 1'b0;
        end else begin
          if (attack) w_pending_nxt = 1'b1;
`ifdef SPRITE_WALK_ANIM_EN
          if (frame_start && moving) begin
            if (w_cnt_last) begin
              w_frame_cnt_nxt = 8'd0;
              w_walk_nxt      = ~r_walk;
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + 8'd1;
            end
          end
`endif
        end
      end
      default: begin
        if (frame_start) begin
          if (w_cnt_last) begin
            w_frame_cnt_nxt = 8'd0;
            case (r_state)
              POSE_SWING1: w_state_nxt = POSE_SWING2;
              POSE_SWING2: w_state_nxt = POSE_SWING3;
              POSE_SWING3: w_state_nxt = POSE_SWING4;
              default:     w_state_nxt = POSE_IDLE;
            endcase
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end
    endcase
  end

`ifndef SPRITE_WALK_ANIM_EN
  logic w_unused_moving;
  assign w_unused_moving = moving;
`endif

  // Decoded purely from registers, so the select only moves on a frame_start edge.
  assign spr_sel = pose_sel(r_state, r_walk);
  assign busy    = (r_state != POSE_IDLE);

endmodule

// File: rtl/sprite_pixel_compositor.sv
// Three-stage pixel pipe: ROM addressing, ROM data alignment, transparency and
// palette lookup. Walk animation in pose_fsm is gated by SPRITE_WALK_ANIM_EN.
module sprite_pixel_compositor
  import sprite_pkg::*;
#(
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int BG_W     = 500,
  parameter int BG_H     = 500,
  parameter int ANIM_DIV = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        de,
  input  logic        frame_start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        moving,
  input  logic        attack,
  output logic [17:0] bg_addr,
  input  logic [3:0]  bg_q,
  output logic [9:0]  spr_addr,
  input  logic [2:0]  spr_q,
  output logic [2:0]  spr_sel,
  output logic        busy,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam logic [9:0]  SPR_W_U = 10'(SPR_W);
  localparam logic [9:0]  SPR_H_U = 10'(SPR_H);
  localparam logic [9:0]  BG_W_U  = 10'(BG_W);
  localparam logic [9:0]  BG_H_U  = 10'(BG_H);
  localparam logic [17:0] BG_W_18 = 18'(BG_W);

  logic signed [10:0] w_dx, w_dy;
  logic               w_spr_in, w_bg_in;
  logic [9:0]         w_spr_addr;
  logic [17:0]        w_bg_addr;
  logic [11:0]        w_rgb_nxt;

  logic [9:0]  r_spr_addr;
  logic [17:0] r_bg_addr;
  logic        r_de1, r_spr_in1, r_bg_in1;
  logic        r_de2, r_spr_in2, r_bg_in2;
  logic [11:0] r_rgb;

  // Zero-extend before subtracting so a sprite near the right edge never aliases onto column 0.
  assign w_dx = $signed({1'b0, draw_x}) - $signed({1'b0, sprite_x});
  assign w_dy = $signed({1'b0, draw_y}) - $signed({1'b0, sprite_y});

  assign w_spr_in   = !w_dx[10] && (w_dx[9:0] < SPR_W_U) &&
                      !w_dy[10] && (w_dy[9:0] < SPR_H_U);
  assign w_spr_addr = w_spr_in ? (w_dy[9:0] * SPR_W_U + w_dx[9:0]) : 10'd0;

  assign w_bg_in   = (draw_x < BG_W_U) && (draw_y < BG_H_U);
  assign w_bg_addr = w_bg_in ? (18'(draw_y) * BG_W_18 + 18'(draw_x)) : 18'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_spr_addr <= 10'd0;
      r_bg_addr  <= 18'd0;
      r_de1      <= 1'b0;
      r_spr_in1  <= 1'b0;
      r_bg_in1   <= 1'b0;
      r_de2      <= 1'b0;
      r_spr_in2  <= 1'b0;
      r_bg_in2   <= 1'b0;
      r_rgb      <= 12'h000;
    end else begin
      r_spr_addr <= w_spr_addr;
      r_bg_addr  <= w_bg_addr;
      r_de1      <= de;
      r_spr_in1  <= w_spr_in;
      r_bg_in1   <= w_bg_in;
      // Qualifiers ride one stage behind the addresses to meet the ROM data.
      r_de2      <= r_de1;
      r_spr_in2  <= r_spr_in1;
      r_bg_in2   <= r_bg_in1;
      r_rgb      <= w_rgb_nxt;
    end
  end

  always_comb begin
    w_rgb_nxt = 12'h000;
    if (!r_de2) begin
      w_rgb_nxt = 12'h000;
    end else if (r_spr_in2 && (spr_q != TRANSPARENT_IDX)) begin
      w_rgb_nxt = SPR_PAL[spr_q];
    end else if (r_bg_in2) begin
      w_rgb_nxt = BG_PAL[bg_q];
    end
  end

  pose_fsm #(
    .ANIM_DIV (ANIM_DIV)
  ) u_pose_fsm (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .moving      (moving),
    .attack      (attack),
    .spr_sel     (spr_sel),
    .busy        (busy)
  );

  assign spr_addr = r_spr_addr;
  assign bg_addr  = r_bg_addr;
  assign red      = r_rgb[11:8];
  assign green    = r_rgb[7:4];
  assign blue     = r_rgb[3:0];

endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Directed bench for sprite_pixel_compositor: pipeline addressing, transparency,
// bounds, swing sequencing, reset and walk animation (SPRITE_WALK_ANIM_EN aware).
module tb_sprite_pixel_compositor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y, sprite_x, sprite_y;
  logic        de, frame_start, moving, attack;
  logic [3:0]  bg_q;
  logic [2:0]  spr_q;

  logic [17:0] bg_addr,  bg_addr_w;
  logic [9:0]  spr_addr, spr_addr_w;
  logic [2:0]  spr_sel,  spr_sel_w;
  logic        busy,     busy_w;
  logic [3:0]  red, green, blue, red_w, green_w, blue_w;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sprite_pixel_compositor #(.ANIM_DIV(2)) u_dut (
    .clock(clock), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y), .de(de),
    .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .moving(moving), .attack(attack), .bg_addr(bg_addr), .bg_q(bg_q),
    .spr_addr(spr_addr), .spr_q(spr_q), .spr_sel(spr_sel), .busy(busy),
    .red(red), .green(green), .blue(blue)
  );

  sprite_pixel_compositor #(.ANIM_DIV(8)) u_dut_walk (
    .clock(clock), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y), .de(de),
    .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .moving(moving), .attack(attack), .bg_addr(bg_addr_w), .bg_q(bg_q),
    .spr_addr(spr_addr_w), .spr_q(spr_q), .spr_sel(spr_sel_w), .busy(busy_w),
    .red(red_w), .green(green_w), .blue(blue_w)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0]  exp_sel [9];
    logic [17:0] exp_w8, exp_w2;
    exp_sel = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0};

    reset_n = 1'b0; draw_x = '0; draw_y = '0; de = 1'b0; frame_start = 1'b0;
    sprite_x = '0; sprite_y = '0; moving = 1'b0; attack = 1'b0;
    bg_q = '0; spr_q = '0;
    step(); step();
    check("reset_rgb",      18'({red, green, blue}), 18'h000);
    check("reset_sel",      18'(spr_sel), 18'd0);
    check("reset_busy",     18'(busy), 18'd0);
    check("reset_bg_addr",  bg_addr, 18'd0);
    check("reset_spr_addr", 18'(spr_addr), 18'd0);
    reset_n = 1'b1;

    // Sprite pixel (110,60), then out-of-bounds (600,10)
    sprite_x = 10'd100; sprite_y = 10'd50; spr_q = 3'd3; bg_q = 4'd7;
    draw_x = 10'd110; draw_y = 10'd60; de = 1'b1;
    step();
    check("basic_spr_addr", 18'(spr_addr), 18'd330);
    check("basic_bg_addr",  bg_addr, 18'd30110);
    draw_x = 10'd600; draw_y = 10'd10;
    step();
    check("oob_bg_addr",  bg_addr, 18'd0);
    check("oob_spr_addr", 18'(spr_addr), 18'd0);
    check("latency_not_early", 18'({red, green, blue}), 18'h000);
    de = 1'b0;
    step();
    check("basic_rgb_spr3", 18'({red, green, blue}), 18'h0F0);
    step();
    check("oob_rgb_black", 18'({red, green, blue}), 18'h000);

    // Transparent sprite index shows background
    spr_q = 3'd0; draw_x = 10'd110; draw_y = 10'd60; de = 1'b1;
    step();
    check("transp_bg_addr", bg_addr, 18'd30110);
    de = 1'b0;
    step(); step();
    check("transp_rgb_bg7", 18'({red, green, blue}), 18'h7E1);

    // de low blanks even an opaque sprite pixel
    spr_q = 3'd3; de = 1'b0;
    step(); step(); step();
    check("de_low_black", 18'({red, green, blue}), 18'h000);

    // Right-edge sprite, then far-left pixel that must not wrap into it
    sprite_x = 10'd620; draw_x = 10'd639; draw_y = 10'd60; de = 1'b1;
    step();
    check("edge_spr_addr", 18'(spr_addr), 18'd339);
    draw_x = 10'd5;
    step();
    check("nowrap_spr_addr", 18'(spr_addr), 18'd0);
    check("nowrap_bg_addr",  bg_addr, 18'd30005);
    de = 1'b0;
    step();
    check("edge_rgb_spr3", 18'({red, green, blue}), 18'h0F0);
    step();
    check("nowrap_rgb_bg7", 18'({red, green, blue}), 18'h7E1);

    // Swing: attack sets pending; pose changes only at frame_start
    attack = 1'b1;
    step();
    attack = 1'b0;
    step();
    check("pending_sel_hold", 18'(spr_sel), 18'd0);
    check("pending_not_busy", 18'(busy), 18'd0);
    for (int k = 0; k < 9; k++) begin
      if (k == 4) begin
        attack = 1'b1;
        step();
        attack = 1'b0;
        check("midswing_sel_hold", 18'(spr_sel), 18'd3);
      end
      frame_pulse();
      check($sformatf("swing_sel_%0d", k), 18'(spr_sel), 18'(exp_sel[k]));
      check($sformatf("swing_busy_%0d", k), 18'(busy), (k < 8) ? 18'd1 : 18'd0);
    end
    frame_pulse();
    check("midswing_attack_ignored_sel",  18'(spr_sel), 18'd0);
    check("midswing_attack_ignored_busy", 18'(busy), 18'd0);

    // attack coincident with frame_start starts SWING1 on that edge
    sprite_x = 10'd100; draw_x = 10'd110; draw_y = 10'd60; spr_q = 3'd3; de = 1'b1;
    attack = 1'b1; frame_start = 1'b1;
    step();
    attack = 1'b0; frame_start = 1'b0;
    check("simul_sel",  18'(spr_sel), 18'd2);
    check("simul_busy", 18'(busy), 18'd1);
    for (int k = 0; k < 4; k++) frame_pulse();
    check("swing3_sel", 18'(spr_sel), 18'd4);
    check("swing3_rgb", 18'({red, green, blue}), 18'h0F0);

    // Asynchronous reset mid-swing
    reset_n = 1'b0;
    #1;
    check("async_rst_sel",  18'(spr_sel), 18'd0);
    check("async_rst_busy", 18'(busy), 18'd0);
    check("async_rst_rgb",  18'({red, green, blue}), 18'h000);
    step();
    reset_n = 1'b1; de = 1'b0;
    step();

    // Walk animation
    moving = 1'b1;
    for (int f = 1; f <= 24; f++) begin
      frame_pulse();
`ifdef SPRITE_WALK_ANIM_EN
      exp_w8 = 18'((f / 8) % 2);
      exp_w2 = 18'((f / 2) % 2);
`else
      exp_w8 = 18'd0;
      exp_w2 = 18'd0;
`endif
      check($sformatf("walk8_sel_f%0d", f), 18'(spr_sel_w), exp_w8);
      check($sformatf("walk2_sel_f%0d", f), 18'(spr_sel), exp_w2);
    end
    moving = 1'b0;
    frame_pulse();
    frame_pulse();
`ifdef SPRITE_WALK_ANIM_EN
    exp_w8 = 18'd1;
`else
    exp_w8 = 18'd0;
`endif
    check("walk8_hold_sel", 18'(spr_sel_w), exp_w8);
    check("walk2_hold_sel", 18'(spr_sel), 18'd0);
    check("walk_not_busy",  18'(busy_w), 18'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_compositor.md
# sprite_pixel_compositor

Pixel-pipeline stage directly downstream of the background and sprite ROMs. It turns the VGA scan position into ROM addresses, consumes the palette indices the ROMs return one clock later, and applies transparency and palette lookup. It drives 12-bit RGB to the VGA output, and also sequences the player pose (walk frames, four-step sword swing) that selects which sprite ROM output is muxed onto `spr_q`.

## Interface
- `SPR_W`, default 32: sprite width in pixels (power of two).
- `SPR_H`, default 32: sprite height in pixels.
- `BG_W`, default 500: background image width.
- `BG_H`, default 500: background image height.
- `ANIM_DIV`, default 8: video frames per animation step (1..255).
- `clock`  in  1: pixel/system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `draw_x`  in  10: current scan column.
- `draw_y`  in  10: current scan row.
- `de`  in  1: display enable, high on visible pixels.
- `frame_start`  in  1: one-cycle pulse at the start of vertical blank.
- `sprite_x`, `sprite_y`  in  10 each: top-left corner of the player sprite.
- `moving`  in  1: player is walking this frame.
- `attack`  in  1: one-cycle swing request.
- `bg_addr`  out  18: background ROM address.
- `bg_q`  in  4: background palette index, valid one clock after `bg_addr`.
- `spr_addr`  out  10: sprite ROM address.
- `spr_q`  in  3: sprite palette index from the ROM selected by `spr_sel`, valid one clock after `spr_addr`.
- `spr_sel`  out  3: pose select. 0 = walk frame A, 1 = walk frame B, 2..5 = swing 1..4.
- `busy`  out  1: a swing is in progress.
- `red`, `green`, `blue`  out  4 each: pixel colour.

## Operation
- **Address stage, registered, cycle +1**
  - `dx = draw_x - sprite_x` and `dy = draw_y - sprite_y`, computed at 11 bits signed. No wrap is permitted.
  - `spr_in` is set when `0 <= dx < SPR_W` and `0 <= dy < SPR_H`.
  - `spr_addr = dy*SPR_W + dx` when `spr_in`, else 0.
  - `bg_in` is set when `draw_x < BG_W` and `draw_y < BG_H`.
  - `bg_addr = draw_y*BG_W + draw_x` when `bg_in`, else 0. The multiply uses 18-bit arithmetic.
- **Data stage, cycle +2**
  - ROM data arrives.
  - `de`, `spr_in` and `bg_in` are delayed in lockstep with the addresses.
- **Colour stage, registered, cycle +3**, first matching rule wins:
  - if the delayed `de` is 0, output black;
  - else if `spr_in` and `spr_q != 0`, output `SPR_PAL[spr_q]`;
  - else if `bg_in`, output `BG_PAL[bg_q]`;
  - else black.
  - Sprite index 0 is transparent.
- **Pose FSM**: states IDLE, SWING1, SWING2, SWING3, SWING4.
  - An `attack` pulse in IDLE sets a pending flag.
  - At the next `frame_start`, a pending flag moves the FSM to SWING1, resets the frame counter and clears the flag.
  - Each SWING state holds for `ANIM_DIV` `frame_start` pulses, then advances. SWING4 returns to IDLE.
  - `attack` is ignored while `busy` or while the pending flag is already set.
  - `attack` coinciding with `frame_start` in IDLE starts SWING1 on that same `frame_start`.
  - `busy` = state != IDLE.
  - `spr_sel` = 2..5 in SWING1..4; in IDLE it equals the walk frame.
- **Walk frame**: an 8-bit frame counter increments on `frame_start` while in IDLE with `moving` high. On reaching `ANIM_DIV - 1` it clears and toggles the walk frame. When `moving` is low, the counter and walk frame hold.
- **Tear-free pose changes**: `spr_sel` changes only on a `frame_start` cycle, never mid-frame.
- **Reset**: all outputs are 0, FSM is IDLE, the pending flag, counters and walk frame are cleared, and pipeline valid bits are cleared. Asserting reset mid-swing returns the FSM to IDLE immediately.

## Timing
- Latency is 3 clocks from `draw_x`/`draw_y`/`de` to RGB, fixed and unstalled. The downstream hsync/vsync must be delayed by 3 to match.
- ROM read latency is assumed to be exactly 1 clock, matching the registered-output ROMs.
- One pixel is accepted and one produced every clock. There is no handshake.
- A `frame_start` change of `spr_sel` is registered. The sprite ROM mux may therefore not be combinationally dependent on same-cycle `attack`.

## Configuration
- Macro: `SPRITE_WALK_ANIM_EN`.
- Defined: walk-frame toggling operates as described above.
- Undefined: no walk counter is built, and the walk frame is constant 0 (`spr_sel` = 0 in IDLE). Swing animation is unaffected.

## Structure
- Package `sprite_pkg` holds:
  - the `pose_t` enum (IDLE, SWING1..4);
  - `spr_sel` encodings;
  - `SPR_PAL[0:7]` and `BG_PAL[0:15]` as 12-bit RGB constants;
  - the transparent index constant (0).
- One sub-module, `pose_fsm`, contains the swing FSM, the pending flag and the walk counter. The compositor top holds the 3-stage pixel pipe.

## Test plan
- **Basic pipeline**: reset, then `sprite_x=100`, `sprite_y=50`, scan pixel (110,60), `de=1`.
  - `spr_addr` is 10*32+10 = 330 one clock later.
  - With `spr_q=3` returned, RGB equals `SPR_PAL[3]` three clocks after input.
- **Transparency**: same pixel with `spr_q=0` and `bg_q=7` → RGB equals `BG_PAL[7]`. `bg_addr` is 60*500+110 = 30110.
- **Bounds**:
  - Pixel (600,10) gives `bg_in=0`, `bg_addr=0` and black output.
  - `sprite_x=620`, pixel (639,y) gives dx=19 and `spr_in=1`.
  - Pixel (5,y) with `sprite_x=620` gives `spr_in=0`, with no wrap.
- **Swing sequence**:
  - `attack` pulse, then `ANIM_DIV=2` → `spr_sel` goes 2,2,3,3,4,4,5,5 on successive `frame_start` pulses, then 0.
  - `busy` is high throughout.
  - A second `attack` mid-swing is ignored.
- **Simultaneous events and reset**:
  - `attack` in the same cycle as `frame_start` → SWING1 (`spr_sel=2`) on the next clock.
  - `reset_n` low during SWING3 → `spr_sel=0`, `busy=0` and RGB 0 immediately.
- **Walk animation**, with `SPRITE_WALK_ANIM_EN` defined, `moving=1`, `ANIM_DIV=8` → `spr_sel` toggles 0↔1 every 8 frames.
  - Undefined → `spr_sel` stays 0.
